// File: rtl/fb_arbiter.sv
// rtl/fb_arbiter.sv - frame-buffer burst arbiter: HDMI scan-out read vs two camera writers
//
// Ports:
//   clk_low        pixel clock, sole clock of the block
//   reset          asynchronous active-low reset
//   req[2:0]       [0] HDMI read, [1] cam0 write, [2] cam1 write; held until granted
//   hdmi_urgent    HDMI line FIFO below low-water mark
//   addr0..addr2   burst address per requester, valid while its req is high
//   gnt[2:0]       one-hot single-cycle grant pulse
//   mem_cmd_*      command to the memory controller (valid/ready handshake, we, addr, id)
//   mem_done       single-cycle pulse when the accepted burst finishes
//   busy           high whenever the FSM is not idle
module fb_arbiter #(
    parameter int ADDR_W   = 24,
    parameter int MAX_WAIT = 255
) (
    input  logic              clk_low,
    input  logic              reset,
    input  logic [2:0]        req,
    input  logic              hdmi_urgent,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    output logic [2:0]        gnt,
    output logic              mem_cmd_valid,
    input  logic              mem_cmd_ready,
    output logic              mem_cmd_we,
    output logic [ADDR_W-1:0] mem_cmd_addr,
    output logic [1:0]        mem_cmd_id,
    input  logic              mem_done,
    output logic              busy
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t            state;
    logic [1:0]        rr_ptr;
    logic [CNT_W-1:0]  wait_cnt1;
    logic [CNT_W-1:0]  wait_cnt2;
    logic              starved1;
    logic              starved2;
    logic [1:0]        rr_first;
    logic [1:0]        rr_second;
    logic [1:0]        rr_third;
    logic [1:0]        winner;
    logic              grant_now;
    logic [ADDR_W-1:0] winner_addr;

    function automatic logic req_at(input logic [2:0] r, input logic [1:0] idx);
        case (idx)
            2'd0:    req_at = r[0];
            2'd1:    req_at = r[1];
            default: req_at = r[2];
        endcase
    endfunction

    assign starved1  = req[1] && (wait_cnt1 == CNT_MAX);
    assign starved2  = req[2] && (wait_cnt2 == CNT_MAX);
    assign grant_now = (state == IDLE) && (|req);

    // Round-robin search order starts just after the last winner.
    always_comb begin
        rr_first  = 2'd0;
        rr_second = 2'd1;
        rr_third  = 2'd2;
        case (rr_ptr)
            2'd0: begin
                rr_first  = 2'd1;
                rr_second = 2'd2;
                rr_third  = 2'd0;
            end
            2'd1: begin
                rr_first  = 2'd2;
                rr_second = 2'd0;
                rr_third  = 2'd1;
            end
            default: begin
                rr_first  = 2'd0;
                rr_second = 2'd1;
                rr_third  = 2'd2;
            end
        endcase
    end

    // Urgent HDMI beats a starved writer; the writer then keeps its saturated count.
    always_comb begin
        winner = rr_third;
        if (req[0] && hdmi_urgent) begin
            winner = 2'd0;
        end else if (starved1) begin
            winner = 2'd1;
        end else if (starved2) begin
            winner = 2'd2;
        end else if (req_at(req, rr_first)) begin
            winner = rr_first;
        end else if (req_at(req, rr_second)) begin
            winner = rr_second;
        end
    end

    always_comb begin
        winner_addr = addr0;
        case (winner)
            2'd1:    winner_addr = addr1;
            2'd2:    winner_addr = addr2;
            default: winner_addr = addr0;
        endcase
    end

    // Writers keep counting while another burst runs; that is time they spend waiting too.
    always_ff @(posedge clk_low or negedge reset) begin
        if (!reset) begin
            wait_cnt1 <= '0;
            wait_cnt2 <= '0;
        end else begin
            if (!req[1] || (grant_now && winner == 2'd1)) begin
                wait_cnt1 <= '0;
            end else if (wait_cnt1 != CNT_MAX) begin
                wait_cnt1 <= wait_cnt1 + CNT_W'(1);
            end
            if (!req[2] || (grant_now && winner == 2'd2)) begin
                wait_cnt2 <= '0;
            end else if (wait_cnt2 != CNT_MAX) begin
                wait_cnt2 <= wait_cnt2 + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_low or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            rr_ptr        <= 2'd2;
            gnt           <= 3'b000;
            mem_cmd_valid <= 1'b0;
            mem_cmd_we    <= 1'b0;
            mem_cmd_addr  <= '0;
            mem_cmd_id    <= 2'd0;
            busy          <= 1'b0;
        end else begin
            gnt <= 3'b000;
            case (state)
                IDLE: begin
                    if (grant_now) begin
                        gnt           <= 3'b001 << winner;
                        rr_ptr        <= winner;
                        mem_cmd_valid <= 1'b1;
                        mem_cmd_we    <= (winner != 2'd0);
                        mem_cmd_addr  <= winner_addr;
                        mem_cmd_id    <= winner;
                        busy          <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_cmd_ready) begin
                        mem_cmd_valid <= 1'b0;
                        state         <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (mem_done) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    mem_cmd_valid <= 1'b0;
                    busy          <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fb_arbiter.sv
// tb/tb_fb_arbiter.sv - directed self-checking bench for fb_arbiter
module tb_fb_arbiter;

    localparam int AW = 24;

    logic          clk_low = 1'b0;
    logic          reset = 1'b0;
    logic [2:0]    req = 3'b000;
    logic          hdmi_urgent = 1'b0;
    logic [AW-1:0] addr0 = '0;
    logic [AW-1:0] addr1 = '0;
    logic [AW-1:0] addr2 = '0;
    logic          mem_cmd_ready = 1'b0;
    logic          mem_done = 1'b0;

    logic [2:0]    gnt_a, gnt_b;
    logic          valid_a, valid_b;
    logic          we_a, we_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [1:0]    id_a, id_b;
    logic          busy_a, busy_b;

    logic [2:0]    gnt_s;
    logic          we_s;
    logic [AW-1:0] addr_s;
    logic [1:0]    id_s;

    int errors = 0;
    int checks = 0;
    bit use_b  = 1'b0;

    always #5 clk_low = ~clk_low;

    // Short starvation threshold so starvation is reachable in a few bursts.
    fb_arbiter #(.ADDR_W(AW), .MAX_WAIT(4)) dut (
        .clk_low(clk_low), .reset(reset), .req(req), .hdmi_urgent(hdmi_urgent),
        .addr0(addr0), .addr1(addr1), .addr2(addr2), .gnt(gnt_a),
        .mem_cmd_valid(valid_a), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_we(we_a),
        .mem_cmd_addr(addr_a), .mem_cmd_id(id_a), .mem_done(mem_done), .busy(busy_a)
    );

    // Default threshold so pure round-robin order is never disturbed by starvation.
    fb_arbiter #(.ADDR_W(AW), .MAX_WAIT(255)) dut_rr (
        .clk_low(clk_low), .reset(reset), .req(req), .hdmi_urgent(hdmi_urgent),
        .addr0(addr0), .addr1(addr1), .addr2(addr2), .gnt(gnt_b),
        .mem_cmd_valid(valid_b), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_we(we_b),
        .mem_cmd_addr(addr_b), .mem_cmd_id(id_b), .mem_done(mem_done), .busy(busy_b)
    );

    assign gnt_s  = use_b ? gnt_b  : gnt_a;
    assign we_s   = use_b ? we_b   : we_a;
    assign addr_s = use_b ? addr_b : addr_a;
    assign id_s   = use_b ? id_b   : id_a;

    task automatic tick();
        @(posedge clk_low);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b0;
        req           = 3'b000;
        hdmi_urgent   = 1'b0;
        mem_cmd_ready = 1'b0;
        mem_done      = 1'b0;
        addr0         = '0;
        addr1         = '0;
        addr2         = '0;
        repeat (2) tick();
        reset = 1'b1;
    endtask

    // Waits for a grant (bounded), captures the command, then finishes the burst
    // with ready held high and done sampled done_lat cycles after the handshake.
    task automatic burst(input int done_lat, input bit drop,
                         output logic [2:0] g, output logic [2:0] g_after,
                         output logic [1:0] id, output logic we,
                         output logic [AW-1:0] a, output bit ok);
        ok = 1'b0; g = 3'b000; g_after = 3'b111; id = 2'd3; we = 1'bx; a = 'x;
        for (int i = 0; i < 40 && !ok; i++) begin
            tick();
            if (gnt_s != 3'b000) begin
                ok = 1'b1; g = gnt_s; id = id_s; we = we_s; a = addr_s;
            end
        end
        if (ok) begin
            if (drop) req = req & ~g;
            tick();
            g_after = gnt_s;
            repeat (done_lat - 1) tick();
            mem_done = 1'b1;
            tick();
            mem_done = 1'b0;
        end
    endtask

    task automatic test_reset();
        use_b = 1'b0;
        do_reset();
        checks++; if (gnt_a !== 3'b000) begin errors++; $display("FAIL reset_gnt: got %b want 000", gnt_a); end
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_a); end
        checks++; if (we_a !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", we_a); end
        checks++; if (addr_a !== 24'h0) begin errors++; $display("FAIL reset_addr: got %h want 000000", addr_a); end
        checks++; if (id_a !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d want 0", id_a); end
        checks++; if ({busy_a, busy_b} !== 2'b00) begin errors++; $display("FAIL reset_busy: got %b want 00", {busy_a, busy_b}); end
    endtask

    task automatic test_single_read();
        int busy_cnt;
        use_b = 1'b0;
        do_reset();
        addr0 = 24'h000100;
        mem_cmd_ready = 1'b1;
        req = 3'b001;
        tick();
        checks++; if (gnt_a !== 3'b001) begin errors++; $display("FAIL single_gnt: got %b want 001", gnt_a); end
        checks++; if ({valid_a, we_a, id_a} !== 4'b1000) begin errors++; $display("FAIL single_cmd: valid/we/id got %b want 1000", {valid_a, we_a, id_a}); end
        checks++; if (addr_a !== 24'h000100) begin errors++; $display("FAIL single_addr: got %h want 000100", addr_a); end
        req = 3'b000;
        busy_cnt = busy_a ? 1 : 0;
        tick();
        checks++; if ({gnt_a, valid_a} !== 4'b0000) begin errors++; $display("FAIL single_after_ready: gnt/valid got %b want 0000", {gnt_a, valid_a}); end
        if (busy_a) busy_cnt++;
        tick();
        if (busy_a) busy_cnt++;
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        if (busy_a) busy_cnt++;
        checks++; if (busy_cnt != 3) begin errors++; $display("FAIL single_busy_cycles: got %0d want 3", busy_cnt); end
    endtask

    task automatic test_round_robin();
        logic [2:0] g, ga;
        logic [1:0] id;
        logic we;
        logic [AW-1:0] a;
        bit ok;
        logic [2:0] exp_g;
        logic [1:0] exp_id;
        use_b = 1'b1;
        do_reset();
        mem_cmd_ready = 1'b1;
        req = 3'b111;
        for (int i = 0; i < 6; i++) begin
            exp_id = 2'(i % 3);
            exp_g = 3'b001 << exp_id;
            burst(1, 1'b0, g, ga, id, we, a, ok);
            checks++; if (!ok) begin errors++; $display("FAIL rr_timeout[%0d]: no grant within 40 cycles", i); end
            checks++; if ({g, id} !== {exp_g, exp_id}) begin errors++; $display("FAIL rr_order[%0d]: gnt/id got %b/%0d want %b/%0d", i, g, id, exp_g, exp_id); end
            checks++; if (ga !== 3'b000) begin errors++; $display("FAIL rr_pulse_width[%0d]: gnt next cycle got %b want 000", i, ga); end
        end
        use_b = 1'b0;
    endtask

    task automatic test_urgent_vs_starved();
        logic [2:0] g, ga;
        logic [1:0] id;
        logic we;
        logic [AW-1:0] a;
        bit ok;
        use_b = 1'b0;
        do_reset();
        addr0 = 24'h111111;
        addr2 = 24'h222222;
        mem_cmd_ready = 1'b1;
        hdmi_urgent = 1'b1;
        req = 3'b101;
        // Third HDMI grant happens with cam1 already saturated at MAX_WAIT.
        for (int i = 0; i < 3; i++) begin
            burst(1, 1'b0, g, ga, id, we, a, ok);
            checks++; if ({ok, id, we} !== {1'b1, 2'd0, 1'b0}) begin errors++; $display("FAIL urgent_hdmi[%0d]: ok/id/we got %b/%0d/%b want 1/0/0", i, ok, id, we); end
        end
        hdmi_urgent = 1'b0;
        burst(1, 1'b0, g, ga, id, we, a, ok);
        checks++; if ({ok, g, id, we} !== {1'b1, 3'b100, 2'd2, 1'b1}) begin errors++; $display("FAIL starved_cam1: ok/gnt/id/we got %b/%b/%0d/%b want 1/100/2/1", ok, g, id, we); end
        checks++; if (a !== 24'h222222) begin errors++; $display("FAIL starved_cam1_addr: got %h want 222222", a); end
    endtask

    task automatic test_both_starved();
        logic [2:0] g, ga;
        logic [1:0] id;
        logic we;
        logic [AW-1:0] a;
        bit ok;
        use_b = 1'b0;
        do_reset();
        addr1 = 24'h0A0A0A;
        addr2 = 24'h0B0B0B;
        mem_cmd_ready = 1'b1;
        hdmi_urgent = 1'b1;
        req = 3'b111;
        burst(6, 1'b1, g, ga, id, we, a, ok);
        checks++; if ({ok, id} !== {1'b1, 2'd0}) begin errors++; $display("FAIL both_starved_setup: ok/id got %b/%0d want 1/0", ok, id); end
        hdmi_urgent = 1'b0;
        // rr_ptr=0 and both writers saturated: cam0 first.
        burst(6, 1'b0, g, ga, id, we, a, ok);
        checks++; if ({ok, id, a} !== {1'b1, 2'd1, 24'h0A0A0A}) begin errors++; $display("FAIL both_starved_cam0: ok/id/addr got %b/%0d/%h want 1/1/0a0a0a", ok, id, a); end
        // rr_ptr=1 would pick cam1, but cam0 starved again and wins.
        burst(6, 1'b0, g, ga, id, we, a, ok);
        checks++; if ({ok, id} !== {1'b1, 2'd1}) begin errors++; $display("FAIL starved_over_rr: ok/id got %b/%0d want 1/1", ok, id); end
    endtask

    task automatic test_ready_stall();
        use_b = 1'b0;
        do_reset();
        addr1 = 24'hABCDEF;
        req = 3'b010;
        tick();
        checks++; if ({gnt_a, valid_a, we_a, id_a} !== {3'b010, 1'b1, 1'b1, 2'd1}) begin errors++; $display("FAIL stall_grant: gnt/valid/we/id got %b/%b/%b/%0d want 010/1/1/1", gnt_a, valid_a, we_a, id_a); end
        req = 3'b000;
        for (int i = 0; i < 10; i++) begin
            mem_done = 1'b1;
            tick();
            checks++; if ({valid_a, busy_a, gnt_a, addr_a} !== {1'b1, 1'b1, 3'b000, 24'hABCDEF}) begin errors++; $display("FAIL stall_hold[%0d]: valid/busy/gnt/addr got %b/%b/%b/%h want 1/1/000/abcdef", i, valid_a, busy_a, gnt_a, addr_a); end
        end
        mem_done = 1'b0;
        mem_cmd_ready = 1'b1;
        tick();
        mem_cmd_ready = 1'b0;
        checks++; if ({valid_a, busy_a} !== 2'b01) begin errors++; $display("FAIL stall_accept: valid/busy got %b want 01", {valid_a, busy_a}); end
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL stall_done: busy got %b want 0", busy_a); end
    endtask

    task automatic test_reset_mid_burst();
        logic [2:0] g, ga;
        logic [1:0] id;
        logic we;
        logic [AW-1:0] a;
        bit ok;
        use_b = 1'b0;
        do_reset();
        addr2 = 24'h0F0F0F;
        mem_cmd_ready = 1'b1;
        req = 3'b100;
        tick();
        req = 3'b000;
        tick();
        checks++; if ({busy_a, valid_a, we_a, id_a, addr_a} !== {1'b1, 1'b0, 1'b1, 2'd2, 24'h0F0F0F}) begin errors++; $display("FAIL mid_wait_done: busy/valid/we/id/addr got %b/%b/%b/%0d/%h want 1/0/1/2/0f0f0f", busy_a, valid_a, we_a, id_a, addr_a); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if ({gnt_a, valid_a, we_a, id_a, busy_a} !== 8'b0) begin errors++; $display("FAIL async_reset_ctrl: gnt/valid/we/id/busy got %b/%b/%b/%0d/%b want all 0", gnt_a, valid_a, we_a, id_a, busy_a); end
        checks++; if (addr_a !== 24'h0) begin errors++; $display("FAIL async_reset_addr: got %h want 000000", addr_a); end
        tick();
        reset = 1'b1;
        addr1 = 24'h123456;
        req = 3'b010;
        burst(1, 1'b1, g, ga, id, we, a, ok);
        checks++; if ({ok, g, id, we, a} !== {1'b1, 3'b010, 2'd1, 1'b1, 24'h123456}) begin errors++; $display("FAIL post_reset_grant: ok/gnt/id/we/addr got %b/%b/%0d/%b/%h want 1/010/1/1/123456", ok, g, id, we, a); end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_urgent_vs_starved();
        test_both_starved();
        test_ready_stall();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
